// File: rtl/assoc_cache_pkg.sv
// -----------------------------------------------------------------------------
// assoc_cache_pkg
// Shared definitions for the 2-way set-associative data cache:
//   - default geometry (word address, data, index and counter widths)
//   - derived TAG_W / SETS for the default geometry
//   - FSM state encoding
//   - helpers that split a word address into tag and set index
// -----------------------------------------------------------------------------
package assoc_cache_pkg;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INDEX_W = 10;
  localparam int DEF_CNT_W   = 16;

  localparam int TAG_W = DEF_ADDR_W - DEF_INDEX_W;
  localparam int SETS  = 1 << DEF_INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESP
  } state_e;

  // Upper bits of a word address select the tag.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_ADDR_W-1:DEF_INDEX_W];
  endfunction

  // Low bits of a word address select the set.
  function automatic logic [DEF_INDEX_W-1:0] addr_index(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_INDEX_W-1:0];
  endfunction

endpackage

// File: rtl/assoc_cache_way.sv
// -----------------------------------------------------------------------------
// cache_way
// One way of the set-associative cache: per-set valid, dirty, tag and data.
// Reads are combinational by set index; the write port updates all four
// fields of the addressed set on the rising edge.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears valid/dirty)
//   i_index      set index for both read and write
//   i_we         write the addressed set (valid is set to 1)
//   i_tag        tag to store
//   i_data       data word to store
//   i_dirty      dirty bit to store
//   o_valid      valid bit of the addressed set
//   o_dirty      dirty bit of the addressed set
//   o_tag        stored tag of the addressed set
//   o_data       stored data of the addressed set
// -----------------------------------------------------------------------------
module cache_way
  import assoc_cache_pkg::*;
#(
  parameter int INDEX_W   = DEF_INDEX_W,
  parameter int WAY_TAG_W = TAG_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INDEX_W-1:0]   i_index,
  input  logic                 i_we,
  input  logic [WAY_TAG_W-1:0] i_tag,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_dirty,
  output logic                 o_valid,
  output logic                 o_dirty,
  output logic [WAY_TAG_W-1:0] o_tag,
  output logic [DATA_W-1:0]    o_data
);

  localparam int NUM_SETS = 1 << INDEX_W;

  logic [NUM_SETS-1:0]  r_valid;
  logic [NUM_SETS-1:0]  r_dirty;
  logic [WAY_TAG_W-1:0] r_tag  [NUM_SETS];
  logic [DATA_W-1:0]    r_data [NUM_SETS];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement or block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= i_dirty;
    end
  end

  // NOTE: tag/data storage has no reset; valid gates every use of it, and
  // leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_index]  <= i_tag;
      r_data[i_index] <= i_data;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];

endmodule

// File: rtl/assoc_cache.sv
// -----------------------------------------------------------------------------
// assoc_cache
// 2-way set-associative, write-back, write-allocate data cache, one word per
// line, with per-set LRU replacement and saturating hit/miss counters.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_req_valid    CPU request present (held by the master until accepted)
//   i_req_we       1 = store, 0 = load
//   i_req_addr     request word address
//   i_req_wdata    store data
//   o_req_ready    cache can accept a request (IDLE only)
//   o_resp_valid   one-cycle completion pulse
//   o_resp_rdata   load data, or the stored word for stores
//   o_mem_req      memory transaction active, held until i_mem_ready
//   o_mem_we       1 = writeback, 0 = refill read
//   o_mem_addr     memory word address
//   o_mem_wdata    writeback data
//   i_mem_ready    one-cycle memory completion
//   i_mem_rdata    refill data, valid with i_mem_ready
//   o_hit_count    saturating hit counter
//   o_miss_count   saturating miss counter
// -----------------------------------------------------------------------------
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_req_ready,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  localparam int WAY_TAG_W = ADDR_W - INDEX_W;
  localparam int NUM_SETS  = 1 << INDEX_W;

  // Captured request and per-transaction state
  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_victim;
  // r_lru[set] names the least recently used way of that set
  logic [NUM_SETS-1:0] r_lru;

  // Registered outputs
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [CNT_W-1:0]    r_hit_count;
  logic [CNT_W-1:0]    r_miss_count;

  // Way read/write signals
  logic [INDEX_W-1:0]   w_index;
  logic [WAY_TAG_W-1:0] w_tag;
  logic [1:0]           w_rd_valid;
  logic [1:0]           w_rd_dirty;
  logic [WAY_TAG_W-1:0] w_rd_tag [2];
  logic [DATA_W-1:0]    w_rd_data [2];
  logic [1:0]           w_hit;
  logic                 w_any_hit;
  logic                 w_hit_way;
  logic                 w_victim;
  logic [1:0]           w_way_we;
  logic [DATA_W-1:0]    w_wr_data;
  logic                 w_wr_dirty;

  assign w_index = r_addr[INDEX_W-1:0];
  assign w_tag   = r_addr[ADDR_W-1:INDEX_W];

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way #(
      .INDEX_W  (INDEX_W),
      .WAY_TAG_W(WAY_TAG_W),
      .DATA_W   (DATA_W)
    ) u_way (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_index(w_index),
      .i_we   (w_way_we[g]),
      .i_tag  (w_tag),
      .i_data (w_wr_data),
      .i_dirty(w_wr_dirty),
      .o_valid(w_rd_valid[g]),
      .o_dirty(w_rd_dirty[g]),
      .o_tag  (w_rd_tag[g]),
      .o_data (w_rd_data[g])
    );
  end

  // Tag compare and victim choice for the captured request.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      w_hit[w] = w_rd_valid[w] && (w_rd_tag[w] == w_tag);
    end
    w_any_hit = |w_hit;
    w_hit_way = w_hit[1];
    if (!w_rd_valid[0])      w_victim = 1'b0;
    else if (!w_rd_valid[1]) w_victim = 1'b1;
    else                     w_victim = r_lru[w_index];
  end

  // Way write port: store hits in LOOKUP, line install at refill completion.
  // Gated by rst_n so a reset edge never installs a partial line.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_way_we   = 2'b00;
    w_wr_data  = r_wdata;
    w_wr_dirty = 1'b1;
    if (rst_n) begin
      if (r_state == ST_LOOKUP && w_any_hit && r_we) begin
        w_way_we[w_hit_way] = 1'b1;
      end else if (r_state == ST_REFILL && i_mem_ready) begin
        w_way_we[r_victim] = 1'b1;
        w_wr_data          = r_we ? r_wdata : i_mem_rdata;
        w_wr_dirty         = r_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_victim     <= 1'b0;
      r_lru        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_addr      <= i_req_addr;
            r_we        <= i_req_we;
            r_wdata     <= i_req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (w_any_hit) begin
            r_lru[w_index] <= ~w_hit_way;
            r_resp_rdata   <= r_we ? r_wdata : w_rd_data[w_hit_way];
            r_resp_valid   <= 1'b1;
            if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_W'(1);
            r_state        <= ST_RESP;
          end else begin
            if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
            r_victim  <= w_victim;
            r_mem_req <= 1'b1;
            // Only a valid dirty victim needs to go back to memory first.
            if (w_rd_valid[w_victim] && w_rd_dirty[w_victim]) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {w_rd_tag[w_victim], w_index};
              r_mem_wdata <= w_rd_data[w_victim];
              r_state     <= ST_WRITEBACK;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_addr;
              r_state    <= ST_REFILL;
            end
          end
        end

        ST_WRITEBACK: begin
          // mem_req stays high; the refill read follows directly.
          if (i_mem_ready) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_addr;
            r_state    <= ST_REFILL;
          end
        end

        ST_REFILL: begin
          if (i_mem_ready) begin
            r_mem_req       <= 1'b0;
            r_lru[w_index]  <= ~r_victim;
            r_resp_rdata    <= r_we ? r_wdata : i_mem_rdata;
            r_resp_valid    <= 1'b1;
            r_state         <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_assoc_cache.sv
// -----------------------------------------------------------------------------
// tb_assoc_cache
// Self-checking bench for assoc_cache: directed vector table, a reset-during-
// refill sequence, and randomized traffic against a recency-list cache model.
// Memory: mem[a] = 32'hA000_0000 | a until written back, 3-cycle ready delay.
// -----------------------------------------------------------------------------
module tb_assoc_cache;
  import assoc_cache_pkg::*;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int CW = 5;   // narrow counters so saturation is reachable
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, req_ready, resp_valid;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, resp_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  assoc_cache #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(10), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_req_ready(req_ready),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- backing memory with 3-cycle ready ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_txn_t;

  logic [DW-1:0] mem_arr [int];
  mem_txn_t      mem_log [$];
  int            wait_cnt;

  function automatic logic [DW-1:0] bench_mem_read(input int a);
    return mem_arr.exists(a) ? mem_arr[a] : (32'hA000_0000 | DW'(a));
  endfunction

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (rst_n && mem_req) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          wait_cnt  = 0;
          mem_ready = 1'b1;
          if (mem_we) begin
            mem_arr[int'(mem_addr)] = mem_wdata;
            mem_log.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = bench_mem_read(int'(mem_addr));
            mem_log.push_back('{1'b0, mem_addr, mem_rdata});
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        output logic [DW-1:0] rdata, output int lat, output bit ok);
    int guard;
    ok = 1'b0; lat = 0; rdata = '0; guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready) begin
      mem_log.delete();
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);            // acceptance edge
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      if (resp_valid) begin
        ok    = 1'b1;
        rdata = resp_rdata;
      end
    end
  endtask

  int exp_hits, exp_misses;

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // Runs one request and compares it against the given expectations.
  task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                         input bit exp_hit, input bit exp_wb,
                         input logic [AW-1:0] wb_addr, input logic [DW-1:0] wb_data);
    logic [DW-1:0] rdata;
    int lat, n_exp;
    bit ok;
    do_req(we, addr, wdata, rdata, lat, ok);
    check({tag, " responded"}, 64'(ok), 64'd1);
    check({tag, " rdata"}, 64'(rdata), 64'(exp_rdata));
    if (exp_hit) exp_hits++; else exp_misses++;
    n_exp = exp_hit ? 0 : (exp_wb ? 2 : 1);
    check({tag, " mem txn count"}, 64'(mem_log.size()), 64'(n_exp));
    if (exp_hit) check({tag, " hit latency"}, 64'(lat), 64'd2);
    if (exp_wb && mem_log.size() == 2) begin
      check({tag, " wb we"},   64'(mem_log[0].we),   64'd1);
      check({tag, " wb addr"}, 64'(mem_log[0].addr), 64'(wb_addr));
      check({tag, " wb data"}, 64'(mem_log[0].data), 64'(wb_data));
    end
    if (!exp_hit && mem_log.size() == n_exp) begin
      check({tag, " refill we"},   64'(mem_log[n_exp-1].we),   64'd0);
      check({tag, " refill addr"}, 64'(mem_log[n_exp-1].addr), 64'(addr));
    end
    check({tag, " hit_count"},  64'(hit_count),  64'(sat(exp_hits)));
    check({tag, " miss_count"}, 64'(miss_count), 64'(sat(exp_misses)));
  endtask

  // ---------------- reference model: per-set recency lists ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
    logic             dirty;
  } line_t;

  line_t         model_lines [4][$];   // front = most recently used
  logic [DW-1:0] model_mem [int];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : (32'hA000_0000 | DW'(a));
  endfunction

  task automatic model_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              output logic [DW-1:0] rdata, output bit hit, output bit wb,
                              output logic [AW-1:0] wb_addr, output logic [DW-1:0] wb_data);
    int s, pos;
    line_t ln;
    s = int'(addr_index(addr));
    pos = -1; hit = 1'b0; wb = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < model_lines[s].size(); i++)
      if (model_lines[s][i].tag == addr_tag(addr)) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      ln = model_lines[s][pos];
      model_lines[s].delete(pos);
      if (we) begin
        ln.data  = wdata;
        ln.dirty = 1'b1;
      end
    end else begin
      if (model_lines[s].size() == 2) begin
        ln = model_lines[s].pop_back();
        if (ln.dirty) begin
          wb      = 1'b1;
          wb_addr = {ln.tag, addr_index(addr)};
          wb_data = ln.data;
          model_mem[int'(wb_addr)] = ln.data;
        end
      end
      ln.tag   = addr_tag(addr);
      ln.dirty = we;
      ln.data  = we ? wdata : model_read(addr);
    end
    rdata = ln.data;
    model_lines[s].push_front(ln);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    bit            exp_hit;
    bit            exp_wb;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [DW-1:0] m_rdata, m_wb_data, wdata;
    logic [AW-1:0] m_wb_addr, addr;
    bit m_hit, m_wb, we;
    int guard;

    vecs[0] = '{1'b0, 17'h1380B, 32'h0,         32'hA001_380B, 1'b0, 1'b0, 17'h0,      32'h0};
    vecs[1] = '{1'b1, 17'h1380B, 32'h11111FFF,  32'h11111FFF,  1'b1, 1'b0, 17'h0,      32'h0};
    vecs[2] = '{1'b0, 17'h1380B, 32'h0,         32'h11111FFF,  1'b1, 1'b0, 17'h0,      32'h0};
    vecs[3] = '{1'b0, 17'h1F80B, 32'h0,         32'hA001_F80B, 1'b0, 1'b0, 17'h0,      32'h0};
    vecs[4] = '{1'b0, 17'h1380B, 32'h0,         32'h11111FFF,  1'b1, 1'b0, 17'h0,      32'h0};
    vecs[5] = '{1'b0, 17'h1780B, 32'h0,         32'hA001_780B, 1'b0, 1'b0, 17'h0,      32'h0};
    vecs[6] = '{1'b0, 17'h1F80B, 32'h0,         32'hA001_F80B, 1'b0, 1'b1, 17'h1380B, 32'h11111FFF};
    vecs[7] = '{1'b1, 17'h1580B, 32'hAAAA1111,  32'hAAAA1111,  1'b0, 1'b0, 17'h0,      32'h0};
    vecs[8] = '{1'b0, 17'h1580B, 32'h0,         32'hAAAA1111,  1'b1, 1'b0, 17'h0,      32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready",  64'(req_ready),  64'd1);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset mem_req",    64'(mem_req),    64'd0);
    check("reset mem_we",     64'(mem_we),     64'd0);
    check("reset mem_addr",   64'(mem_addr),   64'd0);
    check("reset mem_wdata",  64'(mem_wdata),  64'd0);
    check("reset resp_rdata", 64'(resp_rdata), 64'd0);
    check("reset hit_count",  64'(hit_count),  64'd0);
    check("reset miss_count", 64'(miss_count), 64'd0);
    rst_n = 1'b1;

    exp_hits = 0; exp_misses = 0;
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_hit, vecs[i].exp_wb,
              vecs[i].wb_addr, vecs[i].wb_data);
    end

    // Reset while a refill read is waiting on memory.
    @(negedge clk);
    mem_log.delete();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h00123; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rstmid refill started", 64'(mem_req), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid mem_req",    64'(mem_req),    64'd0);
    check("rstmid req_ready",  64'(req_ready),  64'd1);
    check("rstmid hit_count",  64'(hit_count),  64'd0);
    check("rstmid miss_count", 64'(miss_count), 64'd0);
    check("rstmid resp_valid", 64'(resp_valid), 64'd0);
    check("rstmid no mem done", 64'(mem_log.size()), 64'd0);
    rst_n = 1'b1;
    exp_hits = 0; exp_misses = 0;
    // Dirty 1580B was discarded; 1380B was written back before; 00123 never installed.
    run_txn("post-rst 1580B", 1'b0, 17'h1580B, '0, 32'hA001_580B, 1'b0, 1'b0, '0, '0);
    run_txn("post-rst 1380B", 1'b0, 17'h1380B, '0, 32'h11111FFF,  1'b0, 1'b0, '0, '0);
    run_txn("post-rst 00123", 1'b0, 17'h00123, '0, 32'hA000_0123, 1'b0, 1'b0, '0, '0);

    // Randomized traffic over 4 sets x 6 tags against the model.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_hits = 0; exp_misses = 0;
    model_mem = mem_arr;
    for (int s = 0; s < 4; s++) model_lines[s].delete();
    for (int n = 0; n < 300; n++) begin
      addr  = AW'(($urandom_range(0, 5) << 10) | $urandom_range(0, 3));
      we    = ($urandom_range(0, 1) == 1);
      wdata = $urandom;
      model_access(we, addr, wdata, m_rdata, m_hit, m_wb, m_wb_addr, m_wb_data);
      run_txn($sformatf("rnd%0d", n), we, addr, wdata, m_rdata, m_hit, m_wb, m_wb_addr, m_wb_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
